// File: rtl/swap_dispatch.sv
// swap_dispatch: request FIFO and issuer in front of the two-memory swap engine.
// Optional same-cycle bypass when empty and idle: define SWAP_DISPATCH_BYPASS_EN.
module swap_dispatch #(
   parameter int AW    = 32,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [AW-1:0] req_addra,
   input  logic [AW-1:0] req_addrb,
   output logic          start,
   output logic [AW-1:0] addra,
   output logic [AW-1:0] addrb,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] count
);

   localparam int PW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] mem_a_q [DEPTH];
   logic [AW-1:0] mem_b_q [DEPTH];

   logic idle;
   logic has_data;
   logic byp;
   logic push;
   logic pop;

   assign idle     = (state_q == ST_IDLE);
   assign has_data = (count_q != '0);

   // Mirror state register; engine shares rst so both return to IDLE together
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Mirror next state: follows the engine's IDLE->RD->WR->IDLE walk
   always_comb begin
      state_d = ST_IDLE;
      case (state_q)
         ST_IDLE: state_d = start ? ST_RD : ST_IDLE;
         ST_RD:   state_d = ST_WR;
         ST_WR:   state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Issue decode: head of queue first, else optional bypass of the live request
   always_comb begin
`ifdef SWAP_DISPATCH_BYPASS_EN
      byp = idle && !has_data && req_valid;
`else
      byp = 1'b0;
`endif
      pop   = idle && has_data;
      start = pop || byp;
      addra = '0;
      addrb = '0;
      if (pop) begin
         addra = mem_a_q[rptr_q];
         addrb = mem_b_q[rptr_q];
      end else if (byp) begin
         addra = req_addra;
         addrb = req_addrb;
      end
      busy  = !idle;
      done  = (state_q == ST_WR);
   end

   assign req_ready = (count_q != CW'(DEPTH));
   assign count     = count_q;
   assign push      = req_valid && req_ready && !byp;

   // Pointer and occupancy next state; push and pop together leave count alone
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push) begin
         wptr_d = wptr_q + 1'b1;
      end
      if (pop) begin
         rptr_d = rptr_q + 1'b1;
      end
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   // Pointer and occupancy registers; reset drops any queued requests
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Queue storage; contents need no reset since count gates every read
   always_ff @(posedge clk) begin
      if (push) begin
         mem_a_q[wptr_q] <= req_addra;
         mem_b_q[wptr_q] <= req_addrb;
      end
   end

endmodule

// File: tb/tb_swap_dispatch.sv
// tb_swap_dispatch: random and directed stimulus against a queue-based
// reference model of the dispatcher and the engine's three-cycle swap.
module tb_swap_dispatch;

   localparam int AW    = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;
`ifdef SWAP_DISPATCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic [AW-1:0] req_addra;
   logic [AW-1:0] req_addrb;
   logic          start;
   logic [AW-1:0] addra;
   logic [AW-1:0] addrb;
   logic          busy;
   logic          done;
   logic [CW-1:0] count;

   swap_dispatch #(.AW(AW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addra (req_addra),
      .req_addrb (req_addrb),
      .start     (start),
      .addra     (addra),
      .addrb     (addrb),
      .busy      (busy),
      .done      (done),
      .count     (count)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // reference model: pending requests and cycles left in the engine's swap
   logic [2*AW-1:0] mq[$];
   int              eng = 0;
   logic [2*AW-1:0] issued[$];
   bit              saw_full = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // one clock cycle: drive, compare at negedge, advance model at posedge
   task automatic step(input logic v, input logic [AW-1:0] a,
                       input logic [AW-1:0] b, input logic r,
                       output logic acc);
      logic          e_rdy, e_byp, e_pop, e_start;
      logic [AW-1:0] ea, eb;
      rst       = r;
      req_valid = v;
      req_addra = a;
      req_addrb = b;
      e_rdy   = (mq.size() != DEPTH);
      e_pop   = (eng == 0) && (mq.size() != 0);
      e_byp   = BYP && (eng == 0) && (mq.size() == 0) && v;
      e_start = e_pop || e_byp;
      ea = '0;
      eb = '0;
      if (e_pop) begin
         ea = mq[0][2*AW-1:AW];
         eb = mq[0][AW-1:0];
      end else if (e_byp) begin
         ea = a;
         eb = b;
      end
      @(negedge clk);
      check("req_ready", 64'(req_ready), 64'(e_rdy));
      check("count", 64'(count), 64'(mq.size()));
      check("start", 64'(start), 64'(e_start));
      check("addra", 64'(addra), 64'(ea));
      check("addrb", 64'(addrb), 64'(eb));
      check("busy", 64'(busy), 64'(eng != 0));
      check("done", 64'(done), 64'(eng == 1));
      if (start) issued.push_back({addra, addrb});
      if (count == CW'(DEPTH)) saw_full = 1'b1;
      acc = v && e_rdy;
      @(posedge clk);
      if (r) begin
         mq.delete();
         eng = 0;
      end else begin
         if (e_start) begin
            if (!e_byp) void'(mq.pop_front());
            eng = 2;
         end else if (eng > 0) begin
            eng--;
         end
         if (v && e_rdy && !e_byp) mq.push_back({a, b});
      end
      #1;
   endtask

   task automatic idle_n(input int n);
      logic acc;
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, acc);
   endtask

   initial begin
      logic acc;
      int   sent;
      int   nst;
      rst       = 1'b1;
      req_valid = 1'b0;
      req_addra = '0;
      req_addrb = '0;
      repeat (2) @(posedge clk);
      #1;

      // reset state held across idle cycles
      idle_n(10);

      // single request
      issued.delete();
      idle_n(5);
      step(1'b1, 32'h10, 32'h20, 1'b0, acc);
      idle_n(6);
      check("single_n", 64'(issued.size()), 64'd1);
      if (issued.size() > 0)
         check("single_addr", 64'(issued[0]), {32'h10, 32'h20});

      // burst of six with valid held
      issued.delete();
      saw_full = 1'b0;
      sent = 0;
      for (int k = 0; k < 60 && sent < 6; k++) begin
         step(1'b1, AW'(sent), AW'(32'h100 + sent), 1'b0, acc);
         if (acc) sent++;
      end
      check("burst_sent", 64'(sent), 64'd6);
      idle_n(20);
      check("burst_full", 64'(saw_full), 64'd1);
      check("burst_n", 64'(issued.size()), 64'd6);
      for (int i = 0; i < 6 && i < issued.size(); i++)
         check("burst_order", 64'(issued[i]),
               {32'(i), 32'(32'h100 + i)});

      // reset while the engine is in its read cycle with work queued
      for (int i = 0; i < 4; i++)
         step(1'b1, AW'(32'h40 + i), AW'(32'h50 + i), 1'b0, acc);
      for (int k = 0; k < 10 && !(eng == 2 && mq.size() == 2); k++)
         idle_n(1);
      check("rst_setup", 64'(eng == 2 && mq.size() == 2), 64'd1);
      step(1'b0, '0, '0, 1'b1, acc);
      issued.delete();
      idle_n(3);
      check("rst_no_issue", 64'(issued.size()), 64'd0);
      step(1'b1, 32'h77, 32'h88, 1'b0, acc);
      idle_n(5);
      check("rst_after_n", 64'(issued.size()), 64'd1);
      if (issued.size() > 0)
         check("rst_after", 64'(issued[0]), {32'h77, 32'h88});

      // bypass directed case: only timing differs from the queued path
      issued.delete();
      idle_n(5);
      step(1'b1, 32'h3, 32'h4, 1'b0, acc);
      nst = issued.size();
      check("byp_same_cycle", 64'(nst), 64'(BYP));
      step(1'b1, 32'h5, 32'h6, 1'b0, acc);
      idle_n(6);
      check("byp_total", 64'(issued.size()), 64'd2);

      // randomized traffic with occasional resets
      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(0, 99) < 55), $urandom, $urandom,
              ($urandom_range(0, 299) == 0), acc);
      end
      idle_n(20);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule
